// File: rtl/timer_ctrl.sv
// hh:mm:ss timer controller: keypad entry, count-down/up run control, 6-digit muxed 7-segment driver.
// Latency: key event acts 1 clk after it is sampled; done/running/seg outputs are registered.
// Backpressure: none; keys are edge events and are dropped when not applicable to the state.
module timer_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_set,
    input  logic        dir,
    input  logic [11:0] keypad,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_com,
    output logic        done,
    output logic        running
);
    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    // Largest representable time; count-up with a zero preset stops here.
    localparam logic [23:0] MAX_TIME = 24'h995959;

    typedef enum logic [2:0] {ST_SET, ST_READY, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    // Time values are packed {h_ten, h_one, m_ten, m_one, s_ten, s_one}, one BCD nibble each.
    state_t        state_q;
    logic [23:0]   disp_q;
    logic [23:0]   preset_q;
    logic [2:0]    cursor_q;
    logic [TW-1:0] tick_q;
    logic          run_dir_q;
    logic          done_q;
    logic          running_q;
    logic [11:0]   keypad_prev_q;
    logic [SW-1:0] scan_cnt_q;
    logic [2:0]    slot_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic [7:0]    seg_com_q;
    logic [7:0]    seg_data_q;

    logic          key_edge, key_single;
    logic          ev_digit, ev_clear, ev_start;
    logic [3:0]    key_digit;
    logic          digit_ok;
    logic [23:0]   step_val;
    logic          step_done;

    // Nibble i counts from s_one (i=0); the tens of minutes/seconds roll at 5, the rest at 9.
    function automatic logic [3:0] nib_limit(input int i);
        return (i == 1 || i == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = nib_limit(i);
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        if (t != MAX_TIME) begin
            for (int i = 0; i < 6; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == nib_limit(i)) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hFC;
            4'd1:    return 8'h60;
            4'd2:    return 8'hDA;
            4'd3:    return 8'hF2;
            4'd4:    return 8'h66;
            4'd5:    return 8'hB6;
            4'd6:    return 8'hBE;
            4'd7:    return 8'hE0;
            4'd8:    return 8'hFE;
            4'd9:    return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    // Key edge detection; multi-key chords are dropped but still consume the edge.
    always_comb begin
        key_edge   = (keypad != 12'd0) && (keypad_prev_q == 12'd0);
        key_single = (keypad & (keypad - 12'd1)) == 12'd0;
        ev_digit   = key_edge && key_single && (keypad[9:0] != 10'd0);
        ev_clear   = key_edge && key_single && keypad[10];
        ev_start   = key_edge && key_single && keypad[11];
        key_digit  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_digit = 4'(i);
        end
        // Tens of minutes/seconds only accept 0-5.
        digit_ok = (cursor_q < 3'd6) &&
                   !((key_digit > 4'd5) && (cursor_q == 3'd2 || cursor_q == 3'd4));
    end

    // One counting step in the current direction and whether it finishes the run.
    always_comb begin
        if (run_dir_q) begin
            step_val  = bcd_inc(disp_q);
            step_done = (preset_q != 24'd0) ? (step_val == preset_q) : (step_val == MAX_TIME);
        end else begin
            step_val  = bcd_dec(disp_q);
            step_done = (step_val == 24'd0);
        end
    end

    // Main control FSM with time registers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_READY;
            disp_q        <= 24'd0;
            preset_q      <= 24'd0;
            cursor_q      <= 3'd0;
            tick_q        <= '0;
            run_dir_q     <= 1'b0;
            done_q        <= 1'b0;
            running_q     <= 1'b0;
            keypad_prev_q <= 12'd0;
        end else begin
            keypad_prev_q <= keypad;
            if (mode_set) begin
                state_q   <= ST_SET;
                done_q    <= 1'b0;
                running_q <= 1'b0;
                if (state_q != ST_SET || ev_clear) begin
                    disp_q   <= 24'd0;
                    cursor_q <= 3'd0;
                end else if (ev_digit && digit_ok) begin
                    for (int i = 0; i < 6; i++) begin
                        if (cursor_q == 3'(i)) disp_q[4*(5-i) +: 4] <= key_digit;
                    end
                    cursor_q <= cursor_q + 3'd1;
                end
            end else begin
                case (state_q)
                    ST_SET: begin
                        preset_q <= disp_q;
                        state_q  <= ST_READY;
                    end
                    ST_READY: begin
                        if (ev_start) begin
                            run_dir_q <= dir;
                            tick_q    <= '0;
                            if (dir) begin
                                disp_q    <= 24'd0;
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end else if (preset_q == 24'd0) begin
                                disp_q  <= preset_q;
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                disp_q    <= preset_q;
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        // Keys win over a coincident tick wrap; tick is frozen on that cycle.
                        if (ev_start) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (ev_clear) begin
                            state_q   <= ST_READY;
                            running_q <= 1'b0;
                        end else if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            disp_q <= step_val;
                            if (step_done) begin
                                state_q   <= ST_DONE;
                                done_q    <= 1'b1;
                                running_q <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (ev_start) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end else if (ev_clear) begin
                            state_q <= ST_READY;
                        end
                    end
                    ST_DONE: begin
                        if (ev_start || ev_clear) begin
                            state_q <= ST_READY;
                            done_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= ST_READY;
                        done_q    <= 1'b0;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Scan slot sequencer, one slot per SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            slot_q     <= 3'd0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            slot_q     <= slot_q + 3'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // Free-running blink phase, toggling every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Segment/common pins registered from the current slot; READY shows the preset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_com_q  <= 8'hFF;
            seg_data_q <= 8'h00;
        end else begin
            logic [23:0] shown;
            logic [3:0]  cur_digit;
            logic        blank;
            shown     = (state_q == ST_READY) ? preset_q : disp_q;
            cur_digit = 4'd0;
            for (int i = 0; i < 6; i++) begin
                if (slot_q == 3'(i)) cur_digit = shown[4*(5-i) +: 4];
            end
            blank = !blink_q && ((state_q == ST_DONE) ||
                    (state_q == ST_SET && cursor_q < 3'd6 && slot_q == cursor_q));
            case (slot_q)
                3'd0:    seg_com_q <= 8'h7F;
                3'd1:    seg_com_q <= 8'hBF;
                3'd2:    seg_com_q <= 8'hDF;
                3'd3:    seg_com_q <= 8'hEF;
                3'd4:    seg_com_q <= 8'hF7;
                3'd5:    seg_com_q <= 8'hFB;
                default: seg_com_q <= 8'hFF;
            endcase
            if (slot_q < 3'd6 && !blank) begin
                seg_data_q <= seg_code(cur_digit) |
                              ((slot_q == 3'd1 || slot_q == 3'd3) ? 8'h01 : 8'h00);
            end else begin
                seg_data_q <= 8'h00;
            end
        end
    end

    assign seg_com  = seg_com_q;
    assign seg_data = seg_data_q;
    assign done     = done_q;
    assign running  = running_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl with TICK_DIV=10, SCAN_DIV=1, BLINK_DIV=5.
// Display is read back through seg_com/seg_data and decoded to BCD.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_timer_ctrl;
    localparam int TICK  = 10;
    localparam int SCAN  = 1;
    localparam int BLINK = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_set = 1'b0;
    logic        dir = 1'b0;
    logic [11:0] keypad = 12'd0;
    logic [7:0]  seg_data, seg_com;
    logic        done, running;

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_lut [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    typedef struct {
        logic [11:0] key;
        logic [23:0] exp_val;
        logic [5:0]  exp_mask;
    } set_vec_t;

    typedef struct {
        logic [7:0] exp_com;
        logic [7:0] exp_data;
    } scan_vec_t;

    set_vec_t  set_tab [13];
    scan_vec_t scan_tab [8];

    always #5 clk = ~clk;

    timer_ctrl #(.TICK_DIV(TICK), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .rst(rst), .mode_set(mode_set), .dir(dir), .keypad(keypad),
        .seg_data(seg_data), .seg_com(seg_com), .done(done), .running(running)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Event lands on the rising edge between the two falling edges; returns just after it.
    task automatic press(input logic [11:0] k);
        @(negedge clk) keypad = k;
        @(negedge clk) keypad = 12'd0;
    endtask

    // Samples n falling edges; merges lit digits into val, records blanked slots in mask.
    task automatic capture(input int n, output logic [23:0] val, output logic [5:0] mask);
        int         slot;
        logic [3:0] d;
        val  = 24'hFFFFFF;
        mask = 6'd0;
        repeat (n) begin
            @(negedge clk);
            case (seg_com)
                8'h7F:   slot = 0;
                8'hBF:   slot = 1;
                8'hDF:   slot = 2;
                8'hEF:   slot = 3;
                8'hF7:   slot = 4;
                8'hFB:   slot = 5;
                default: slot = -1;
            endcase
            if (slot >= 0) begin
                if (seg_data == 8'h00) begin
                    mask[slot] = 1'b1;
                end else begin
                    d = 4'hF;
                    for (int j = 0; j < 10; j++) begin
                        if ((seg_data & 8'hFE) == seg_lut[j]) d = 4'(j);
                    end
                    val[(5-slot)*4 +: 4] = d;
                end
            end
        end
    endtask

    task automatic enter(input logic [23:0] v);
        @(negedge clk) mode_set = 1'b1;
        for (int i = 0; i < 6; i++) begin
            press(12'd1 << v[(5-i)*4 +: 4]);
        end
        @(negedge clk) mode_set = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] val;
        logic [5:0]  mask;

        set_tab[0]  = '{12'h002, 24'h100000, 6'b000010};
        set_tab[1]  = '{12'h004, 24'h120000, 6'b000100};
        set_tab[2]  = '{12'h080, 24'h120000, 6'b000100};
        set_tab[3]  = '{12'h020, 24'h125000, 6'b001000};
        set_tab[4]  = '{12'h400, 24'h000000, 6'b000001};
        set_tab[5]  = '{12'h200, 24'h900000, 6'b000010};
        set_tab[6]  = '{12'h200, 24'h990000, 6'b000100};
        set_tab[7]  = '{12'h020, 24'h995000, 6'b001000};
        set_tab[8]  = '{12'h200, 24'h995900, 6'b010000};
        set_tab[9]  = '{12'h020, 24'h995950, 6'b100000};
        set_tab[10] = '{12'h200, 24'h995959, 6'b000000};
        set_tab[11] = '{12'h008, 24'h995959, 6'b000000};
        set_tab[12] = '{12'h003, 24'h995959, 6'b000000};

        scan_tab[0] = '{8'h7F, 8'hFC};
        scan_tab[1] = '{8'hBF, 8'hFD};
        scan_tab[2] = '{8'hDF, 8'hFC};
        scan_tab[3] = '{8'hEF, 8'hFD};
        scan_tab[4] = '{8'hF7, 8'hFC};
        scan_tab[5] = '{8'hFB, 8'hFC};
        scan_tab[6] = '{8'hFF, 8'h00};
        scan_tab[7] = '{8'hFF, 8'h00};

        // Power-on reset values
        #1 rst = 1'b0;
        #1;
        chk("rst_com", 32'(seg_com), 32'hFF);
        chk("rst_data", 32'(seg_data), 32'h00);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        @(negedge clk) rst = 1'b1;
        wait_n(2);

        // Count-down 00:00:12 reaches zero 120 cycles after START
        dir = 1'b0;
        enter(24'h000012);
        press(12'h800);
        wait_n(119);
        chk("cd12_done_early", 32'(done), 32'd0);
        chk("cd12_run_early", 32'(running), 32'd1);
        wait_n(1);
        chk("cd12_done", 32'(done), 32'd1);
        chk("cd12_running", 32'(running), 32'd0);
        capture(40, val, mask);
        chk("cd12_val", 32'(val), 32'h000000);
        chk("cd12_blink", 32'(mask), 32'h3F);
        press(12'h800);
        chk("cd12_ready", 32'(done), 32'd0);

        // Borrow across s_ten/m_one; CLEAR on the wrap cycle wins
        enter(24'h000100);
        press(12'h800);
        wait_n(10);
        capture(8, val, mask);
        chk("borrow_val", 32'(val), 32'h000059);
        chk("borrow_mask", 32'(mask), 32'h0);
        press(12'h400);
        chk("wrapclr_running", 32'(running), 32'd0);
        chk("wrapclr_done", 32'(done), 32'd0);
        capture(40, val, mask);
        chk("ready_shows_preset", 32'(val), 32'h000100);

        // SET entry table: validation, cursor blink position, CLEAR, full cursor, chord
        @(negedge clk) mode_set = 1'b1;
        @(negedge clk);
        capture(40, val, mask);
        chk("set_enter_val", 32'(val), 32'h000000);
        chk("set_enter_mask", 32'(mask), 32'h01);
        for (int i = 0; i < 13; i++) begin
            press(set_tab[i].key);
            capture(40, val, mask);
            chk($sformatf("set_val[%0d]", i), 32'(val), 32'(set_tab[i].exp_val));
            chk($sformatf("set_mask[%0d]", i), 32'(mask), 32'(set_tab[i].exp_mask));
        end
        @(negedge clk) mode_set = 1'b0;
        @(negedge clk);
        capture(40, val, mask);
        chk("set_preset", 32'(val), 32'h995959);

        // Count-up to preset 00:00:03
        enter(24'h000003);
        dir = 1'b1;
        press(12'h800);
        wait_n(10);
        capture(8, val, mask);
        chk("up_step1", 32'(val), 32'h000001);
        wait_n(2);
        capture(8, val, mask);
        chk("up_step2", 32'(val), 32'h000002);
        wait_n(1);
        chk("up_done_early", 32'(done), 32'd0);
        wait_n(1);
        chk("up_done", 32'(done), 32'd1);
        chk("up_running", 32'(running), 32'd0);
        capture(40, val, mask);
        chk("up_val", 32'(val), 32'h000003);
        chk("up_blink", 32'(mask), 32'h3F);
        press(12'h400);
        chk("up_clear", 32'(done), 32'd0);
        dir = 1'b0;

        // Pause mid-second keeps sub-second phase; chords are ignored
        enter(24'h000001);
        press(12'h800);
        wait_n(2);
        press(12'h800);
        chk("pause_running", 32'(running), 32'd0);
        press(12'h003);
        chk("chord_running", 32'(running), 32'd0);
        chk("chord_done", 32'(done), 32'd0);
        @(negedge clk) keypad = 12'h801;
        @(negedge clk) keypad = 12'h800;
        @(negedge clk) keypad = 12'h000;
        chk("held_key_running", 32'(running), 32'd0);
        wait_n(44);
        press(12'h800);
        chk("resume_running", 32'(running), 32'd1);
        wait_n(6);
        chk("resume_done_early", 32'(done), 32'd0);
        wait_n(1);
        chk("resume_done", 32'(done), 32'd1);
        press(12'h400);

        // Asynchronous reset mid-RUN
        enter(24'h000012);
        press(12'h800);
        wait_n(15);
        #2 rst = 1'b0;
        #1;
        chk("arst_com", 32'(seg_com), 32'hFF);
        chk("arst_data", 32'(seg_data), 32'h00);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("scan_com[%0d]", i), 32'(seg_com), 32'(scan_tab[i].exp_com));
            chk($sformatf("scan_data[%0d]", i), 32'(seg_data), 32'(scan_tab[i].exp_data));
        end

        // Count-down START with a zero preset goes straight to DONE
        press(12'h800);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_running", 32'(running), 32'd0);
        press(12'h800);
        chk("zero_ready", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
